// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states,
// special instruction encodings and the IF/ID bundle.
package mips_pkg;

  localparam int unsigned IMEM_WORDS = 101;

  localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;
  localparam logic [31:0] INSTR_SYSCALL = 32'h0000_000C;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid    = 1'b0;
    b.instr    = INSTR_NOP;
    b.pc       = 32'h0;
    b.pc_plus4 = 32'h0;
    return b;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side instruction memory bus: word address out,
// instruction word back in the same cycle.
interface instruction_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;

  modport master (
    output imem_addr,
    input  imem_instr
  );

  modport slave (
    input  imem_addr,
    output imem_instr
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC select (hold / +4 / redirect)
// and alignment and range checks for the fetch stage.
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pc_oor,
  output logic        target_bad
);

  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

  assign pc_plus4   = pc + 32'd4;
  assign pc_oor     = (pc >= LIMIT);
  assign target_bad = (target[1:0] != 2'b00) ||
                      (target >= LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      unique case (1'b1)
        load:    pc <= target;
        adv:     pc <= pc_plus4;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives imem, fills IF/ID, handles stall,
// redirect, syscall halt and out-of-range fetch faults.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master imem,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     if_valid_o,
  output logic [31:0]              if_instr_o,
  output logic [31:0]              if_pc_o,
  output logic [31:0]              if_pc_plus4_o,
  output logic                     halted_o,
  output logic                     fault_o,
  output logic [31:0]              fault_pc_o,
  output logic [CNT_W-1:0]         fetch_count_o
);

  fetch_state_t state, nxt_state;
  if_id_t       ifid, nxt_ifid;
  logic [31:0]  fault_pc, nxt_fault_pc;
  logic [CNT_W-1:0] cnt;

  logic        pc_load, pc_adv, cnt_inc;
  logic [31:0] pc, pc_plus4;
  logic        pc_oor, target_bad;

  fetch_pc_reg #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .adv        (pc_adv),
    .target     (redirect_pc_i),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .pc_oor     (pc_oor),
    .target_bad (target_bad)
  );

  assign imem.imem_addr = pc;

  // HALT reuses the RUN redirect path: a redirect means the
  // syscall sat on a wrong path and fetching resumes.
  always_comb begin
    nxt_state    = state;
    nxt_ifid     = ifid;
    nxt_fault_pc = fault_pc;
    pc_load      = 1'b0;
    pc_adv       = 1'b0;
    cnt_inc      = 1'b0;
    unique case (state)
      RUN, HALT: begin
        if (redirect_i) begin
          nxt_ifid = if_id_bubble();
          if (target_bad) begin
            nxt_state    = FAULT;
            nxt_fault_pc = redirect_pc_i;
          end else begin
            nxt_state = RUN;
            pc_load   = 1'b1;
          end
        end else if (stall_i) begin
          nxt_ifid = ifid;
        end else if (state == HALT) begin
          nxt_ifid = if_id_bubble();
        end else if (pc_oor) begin
          nxt_ifid     = if_id_bubble();
          nxt_state    = FAULT;
          nxt_fault_pc = pc;
        end else begin
          nxt_ifid.valid    = 1'b1;
          nxt_ifid.instr    = imem.imem_instr;
          nxt_ifid.pc       = pc;
          nxt_ifid.pc_plus4 = pc_plus4;
          cnt_inc           = 1'b1;
          if (imem.imem_instr == INSTR_SYSCALL)
            nxt_state = HALT;
          else
            pc_adv = 1'b1;
        end
      end
      default: begin
        nxt_ifid = if_id_bubble();
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      ifid     <= if_id_bubble();
      fault_pc <= 32'h0;
      cnt      <= '0;
    end else begin
      state    <= nxt_state;
      ifid     <= nxt_ifid;
      fault_pc <= nxt_fault_pc;
      if (cnt_inc)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign if_valid_o    = ifid.valid;
  assign if_instr_o    = ifid.instr;
  assign if_pc_o       = ifid.pc;
  assign if_pc_plus4_o = ifid.pc_plus4;
  assign halted_o      = (state == HALT);
  assign fault_o       = (state == FAULT);
  assign fault_pc_o    = fault_pc;
  assign fetch_count_o = cnt;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a
// combinational program memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        halted_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  logic [31:0] fetch_count_o;

  int n_cmp;
  int n_err;

  logic [31:0] mem [0:100];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus4_o (if_pc_plus4_o),
    .halted_o      (halted_o),
    .fault_o       (fault_o),
    .fault_pc_o    (fault_pc_o),
    .fetch_count_o (fetch_count_o)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (a < 32'd404) return mem[idx];
    return 32'h0;
  endfunction

  assign bus.imem_instr = rd(bus.imem_addr);

  function automatic logic [31:0] word(input int i);
    if (i == 32) return 32'h0000_000C;
    return 32'h2008_0000 + 32'(i);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 32'(if_valid_o), 32'd0);
    chk({tag, ".instr"}, if_instr_o, 32'h0);
    chk({tag, ".pc"}, if_pc_o, 32'h0);
    chk({tag, ".pc4"}, if_pc_plus4_o, 32'h0);
    chk({tag, ".addr"}, bus.imem_addr, 32'h0);
    chk({tag, ".halt"}, 32'(halted_o), 32'd0);
    chk({tag, ".fault"}, 32'(fault_o), 32'd0);
    chk({tag, ".fpc"}, fault_pc_o, 32'h0);
    chk({tag, ".cnt"}, fetch_count_o, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i <= 100; i++) mem[i] = word(i);
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    rst_n         = 1'b0;
    #2;
    chk_reset_vals("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // 10 sequential fetches
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("seq%0d.pc", k), if_pc_o, 32'(4 * k));
      chk($sformatf("seq%0d.instr", k), if_instr_o, word(k));
      chk($sformatf("seq%0d.valid", k), 32'(if_valid_o), 32'd1);
    end
    chk("seq.pc4", if_pc_plus4_o, 32'h28);
    chk("seq.cnt", fetch_count_o, 32'd10);
    chk("seq.addr", bus.imem_addr, 32'h28);

    // stall for 3 cycles with pc=0x10
    do_reset();
    for (int k = 0; k < 4; k++) step();
    chk("pre_stall.addr", bus.imem_addr, 32'h10);
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d.pc", k), if_pc_o, 32'h0C);
      chk($sformatf("stall%0d.instr", k), if_instr_o, word(3));
      chk($sformatf("stall%0d.addr", k), bus.imem_addr, 32'h10);
      chk($sformatf("stall%0d.cnt", k), fetch_count_o, 32'd4);
    end
    stall_i = 1'b0;
    step();
    chk("resume.pc", if_pc_o, 32'h10);
    chk("resume.instr", if_instr_o, word(4));
    chk("resume.addr", bus.imem_addr, 32'h14);
    chk("resume.cnt", fetch_count_o, 32'd5);

    // redirect beats a simultaneous stall
    stall_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h24;
    step();
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    chk("redir.valid", 32'(if_valid_o), 32'd0);
    chk("redir.instr", if_instr_o, 32'h0);
    chk("redir.addr", bus.imem_addr, 32'h24);
    chk("redir.cnt", fetch_count_o, 32'd5);
    step();
    chk("redir1.pc", if_pc_o, 32'h24);
    chk("redir1.valid", 32'(if_valid_o), 32'd1);
    chk("redir1.instr", if_instr_o, word(9));
    chk("redir1.cnt", fetch_count_o, 32'd6);

    // run to the syscall at word 32
    for (int k = 0; k < 22; k++) step();
    chk("presys.pc", if_pc_o, 32'h7C);
    chk("presys.halt", 32'(halted_o), 32'd0);
    step();
    chk("sys.instr", if_instr_o, 32'h0000_000C);
    chk("sys.valid", 32'(if_valid_o), 32'd1);
    chk("sys.pc", if_pc_o, 32'h80);
    chk("sys.halt", 32'(halted_o), 32'd1);
    chk("sys.addr", bus.imem_addr, 32'h80);
    chk("sys.cnt", fetch_count_o, 32'd29);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("halt%0d.valid", k), 32'(if_valid_o), 32'd0);
      chk($sformatf("halt%0d.instr", k), if_instr_o, 32'h0);
      chk($sformatf("halt%0d.halt", k), 32'(halted_o), 32'd1);
      chk($sformatf("halt%0d.addr", k), bus.imem_addr, 32'h80);
      chk($sformatf("halt%0d.cnt", k), fetch_count_o, 32'd29);
    end

    // wrong-path syscall: redirect out of HALT
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h1C;
    step();
    redirect_i = 1'b0;
    chk("unhalt.halt", 32'(halted_o), 32'd0);
    chk("unhalt.valid", 32'(if_valid_o), 32'd0);
    chk("unhalt.addr", bus.imem_addr, 32'h1C);
    step();
    chk("unhalt1.pc", if_pc_o, 32'h1C);
    chk("unhalt1.instr", if_instr_o, word(7));
    chk("unhalt1.cnt", fetch_count_o, 32'd30);

    // misaligned redirect target faults
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h1E;
    step();
    chk("mis.fault", 32'(fault_o), 32'd1);
    chk("mis.fpc", fault_pc_o, 32'h1E);
    chk("mis.valid", 32'(if_valid_o), 32'd0);
    chk("mis.addr", bus.imem_addr, 32'h20);
    redirect_pc_i = 32'h0;
    stall_i       = 1'b1;
    for (int k = 0; k < 3; k++) step();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    chk("sticky.fault", 32'(fault_o), 32'd1);
    chk("sticky.fpc", fault_pc_o, 32'h1E);
    chk("sticky.addr", bus.imem_addr, 32'h20);
    chk("sticky.cnt", fetch_count_o, 32'd30);

    // run off the end of memory
    do_reset();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h84;
    step();
    redirect_i = 1'b0;
    chk("tail.addr", bus.imem_addr, 32'h84);
    chk("tail.cnt", fetch_count_o, 32'd0);
    for (int k = 0; k < 68; k++) step();
    chk("last.pc", if_pc_o, 32'h190);
    chk("last.instr", if_instr_o, word(100));
    chk("last.cnt", fetch_count_o, 32'd68);
    chk("last.addr", bus.imem_addr, 32'h194);
    chk("last.fault", 32'(fault_o), 32'd0);
    step();
    chk("oor.fault", 32'(fault_o), 32'd1);
    chk("oor.fpc", fault_pc_o, 32'h194);
    chk("oor.valid", 32'(if_valid_o), 32'd0);
    chk("oor.cnt", fetch_count_o, 32'd68);

    // async reset in the middle of a cycle
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("restart.pc", if_pc_o, 32'h0);
    chk("restart.instr", if_instr_o, word(0));
    chk("restart.valid", 32'(if_valid_o), 32'd1);
    chk("restart.addr", bus.imem_addr, 32'h4);
    chk("restart.cnt", fetch_count_o, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
